// File: rtl/pipeline_hazard_ctrl.sv
// Control/hazard unit for the 5-stage MIPS core. It carries the decoded
// control bundle through the EX, MEM and WB stages, detects load-use
// hazards, squashes on taken branches, selects EX operand forwarding and
// drains the pipe and halts on a syscall.
module pipeline_hazard_ctrl #(
    parameter int REG_AW          = 5,
    parameter int CTRL_W          = 16,
    parameter bit HALT_ON_SYSCALL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_wr,
    input  logic              ex_taken,
    input  logic              go,
    output logic              stall,
    output logic              flush_ifid,
    output logic              halted,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] ex_wr,
    output logic [REG_AW-1:0] mem_wr,
    output logic [REG_AW-1:0] wb_wr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t state_q, state_d;

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_wr_q, ex_wr_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic              mem_valid_q;
    logic [CTRL_W-1:0] mem_ctrl_q;
    logic [REG_AW-1:0] mem_wr_q;
    logic              wb_valid_q;
    logic [CTRL_W-1:0] wb_ctrl_q;
    logic [REG_AW-1:0] wb_wr_q;

    logic load_use;
    logic stall_c;
    logic issue;

    // Forwarding source for one EX operand; MEM result wins over WB, $0 never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic              reads_src,
        input logic [REG_AW-1:0] src,
        input logic              m_valid,
        input logic              m_regwr,
        input logic [REG_AW-1:0] m_wr,
        input logic              w_valid,
        input logic              w_regwr,
        input logic [REG_AW-1:0] w_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (reads_src && m_valid && m_regwr && (m_wr != '0) && (m_wr == src)) begin
            sel = 2'b10;
        end else if (reads_src && w_valid && w_regwr && (w_wr != '0) && (w_wr == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard detection, stall/flush generation and ID->EX issue decision.
    always_comb begin
        load_use = id_valid && ex_valid_q && ex_ctrl_q[1] && (ex_wr_q != '0) &&
                   ((id_ctrl[8] && (id_rs == ex_wr_q)) || (id_ctrl[9] && (id_rt == ex_wr_q)));
        // A taken branch squashes ID, so it overrides any stall reason.
        stall_c  = !ex_taken && (load_use || (state_q != RUN));
        issue    = id_valid && !stall_c && !ex_taken;
    end

    // Next EX contents: the ID instruction when it issues, otherwise a bubble.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_wr_d    = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = id_ctrl;
            ex_wr_d    = id_wr;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
        end
    end

    // Syscall drain/halt sequencing; held in RUN when halting is disabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (HALT_ON_SYSCALL && issue && id_ctrl[7]) state_d = DRAIN;
            DRAIN:   if (wb_valid_q && wb_ctrl_q[7]) state_d = HALTED;
            HALTED:  if (go) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Pipeline control registers and FSM state; MEM and WB always advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_wr_q     <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_wr_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_wr_q     <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_wr_q     <= ex_wr_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_valid_q <= ex_valid_q;
            mem_ctrl_q  <= ex_ctrl_q;
            mem_wr_q    <= ex_wr_q;
            wb_valid_q  <= mem_valid_q;
            wb_ctrl_q   <= mem_ctrl_q;
            wb_wr_q     <= mem_wr_q;
        end
    end

    assign stall      = stall_c;
    assign flush_ifid = ex_taken;
    assign halted     = (state_q == HALTED);
    assign ex_valid   = ex_valid_q;
    assign mem_valid  = mem_valid_q;
    assign wb_valid   = wb_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign mem_ctrl   = mem_ctrl_q;
    assign wb_ctrl    = wb_ctrl_q;
    assign ex_wr      = ex_wr_q;
    assign mem_wr     = mem_wr_q;
    assign wb_wr      = wb_wr_q;
    assign fwd_a      = fwd_sel(ex_ctrl_q[8], ex_rs_q, mem_valid_q, mem_ctrl_q[0], mem_wr_q,
                                wb_valid_q, wb_ctrl_q[0], wb_wr_q);
    assign fwd_b      = fwd_sel(ex_ctrl_q[9], ex_rt_q, mem_valid_q, mem_ctrl_q[0], mem_wr_q,
                                wb_valid_q, wb_ctrl_q[0], wb_wr_q);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one instance with syscall halting, one
// without, both driven by the same directed and random stimulus and compared
// every cycle against a stage-array reference model.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 16;

  localparam logic [CW-1:0] C_RW  = 16'h0001;
  localparam logic [CW-1:0] C_MR  = 16'h0002;
  localparam logic [CW-1:0] C_M2R = 16'h0008;
  localparam logic [CW-1:0] C_SYS = 16'h0080;
  localparam logic [CW-1:0] C_RS  = 16'h0100;
  localparam logic [CW-1:0] C_RT  = 16'h0200;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [CW-1:0] id_ctrl;
  logic [AW-1:0] id_rs, id_rt, id_wr;
  logic          ex_taken, go;

  logic [1:0]    stall_w, flush_w, halted_w, exv_w, memv_w, wbv_w;
  logic [CW-1:0] exc_w [2];
  logic [CW-1:0] memc_w [2];
  logic [CW-1:0] wbc_w [2];
  logic [AW-1:0] exwr_w [2];
  logic [AW-1:0] memwr_w [2];
  logic [AW-1:0] wbwr_w [2];
  logic [1:0]    fa_w [2];
  logic [1:0]    fb_w [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(AW), .CTRL_W(CW), .HALT_ON_SYSCALL(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_wr(id_wr), .ex_taken(ex_taken), .go(go),
    .stall(stall_w[0]), .flush_ifid(flush_w[0]), .halted(halted_w[0]),
    .ex_valid(exv_w[0]), .mem_valid(memv_w[0]), .wb_valid(wbv_w[0]),
    .ex_ctrl(exc_w[0]), .mem_ctrl(memc_w[0]), .wb_ctrl(wbc_w[0]),
    .ex_wr(exwr_w[0]), .mem_wr(memwr_w[0]), .wb_wr(wbwr_w[0]),
    .fwd_a(fa_w[0]), .fwd_b(fb_w[0])
  );

  pipeline_hazard_ctrl #(.REG_AW(AW), .CTRL_W(CW), .HALT_ON_SYSCALL(1'b0)) dut_nohalt (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_wr(id_wr), .ex_taken(ex_taken), .go(go),
    .stall(stall_w[1]), .flush_ifid(flush_w[1]), .halted(halted_w[1]),
    .ex_valid(exv_w[1]), .mem_valid(memv_w[1]), .wb_valid(wbv_w[1]),
    .ex_ctrl(exc_w[1]), .mem_ctrl(memc_w[1]), .wb_ctrl(wbc_w[1]),
    .ex_wr(exwr_w[1]), .mem_wr(memwr_w[1]), .wb_wr(wbwr_w[1]),
    .fwd_a(fa_w[1]), .fwd_b(fb_w[1])
  );

  // Reference model: stage slots [0]=EX, [1]=MEM, [2]=WB per instance.
  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [AW-1:0] wr;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } stg_t;

  stg_t pipe [2][3];
  int   mode [2];   // 0 running, 1 draining, 2 halted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_hazard(input int k);
    stg_t e;
    e = pipe[k][0];
    return id_valid && e.v && e.c[1] && (e.wr != 0) &&
           ((id_ctrl[8] && id_rs == e.wr) || (id_ctrl[9] && id_rt == e.wr));
  endfunction

  function automatic logic m_stall(input int k);
    return !ex_taken && (m_hazard(k) || mode[k] != 0);
  endfunction

  function automatic logic [1:0] m_fwd(input int k, input logic reads, input logic [AW-1:0] r);
    if (reads && pipe[k][1].v && pipe[k][1].c[0] && pipe[k][1].wr != 0 && pipe[k][1].wr == r)
      return 2'b10;
    if (reads && pipe[k][2].v && pipe[k][2].c[0] && pipe[k][2].wr != 0 && pipe[k][2].wr == r)
      return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = '0;
      mode[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic acc;
      logic wb_sys;
      stg_t nw;
      acc    = id_valid && !m_stall(k) && !ex_taken;
      wb_sys = pipe[k][2].v && pipe[k][2].c[7];
      if (mode[k] == 0 && k == 0 && acc && id_ctrl[7]) mode[k] = 1;
      else if (mode[k] == 1 && wb_sys) mode[k] = 2;
      else if (mode[k] == 2 && go) mode[k] = 0;
      nw = '0;
      if (acc) nw = '{v: 1'b1, c: id_ctrl, wr: id_wr, rs: id_rs, rt: id_rt};
      pipe[k][2] = pipe[k][1];
      pipe[k][1] = pipe[k][0];
      pipe[k][0] = nw;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      string s;
      s = (k == 0) ? "halt" : "nohalt";
      chk({s, ".stall"},     stall_w[k],  m_stall(k));
      chk({s, ".flush"},     flush_w[k],  ex_taken);
      chk({s, ".halted"},    halted_w[k], mode[k] == 2);
      chk({s, ".ex_valid"},  exv_w[k],    pipe[k][0].v);
      chk({s, ".mem_valid"}, memv_w[k],   pipe[k][1].v);
      chk({s, ".wb_valid"},  wbv_w[k],    pipe[k][2].v);
      chk({s, ".ex_ctrl"},   exc_w[k],    pipe[k][0].c);
      chk({s, ".mem_ctrl"},  memc_w[k],   pipe[k][1].c);
      chk({s, ".wb_ctrl"},   wbc_w[k],    pipe[k][2].c);
      chk({s, ".ex_wr"},     exwr_w[k],   pipe[k][0].wr);
      chk({s, ".mem_wr"},    memwr_w[k],  pipe[k][1].wr);
      chk({s, ".wb_wr"},     wbwr_w[k],   pipe[k][2].wr);
      chk({s, ".fwd_a"},     fa_w[k],     m_fwd(k, pipe[k][0].c[8], pipe[k][0].rs));
      chk({s, ".fwd_b"},     fb_w[k],     m_fwd(k, pipe[k][0].c[9], pipe[k][0].rt));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic set_id(input logic v, input logic [CW-1:0] c,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] wr);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_wr = wr;
  endtask

  task automatic idle();
    set_id(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; ex_taken = 1'b0;
    idle();
    model_reset();
    #3;
    compare_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Load-use: lw $8 then add reading $8.
    set_id(1'b1, C_RW | C_MR | C_M2R, 5'd29, 5'd0, 5'd8);
    cyc();
    set_id(1'b1, C_RW | C_RS | C_RT, 5'd8, 5'd9, 5'd10);
    settle(); chk("lu.stall", stall_w[0], 1);
    adv();
    settle(); chk("lu.bubble", exv_w[0], 0); chk("lu.release", stall_w[0], 0);
    adv();
    idle();
    settle(); chk("lu.fwd_a", fa_w[0], 2'b01);
    adv();
    repeat (3) cyc();

    // Forwarding priority: MEM beats WB, then the same with $0.
    set_id(1'b1, C_RW, 5'd0, 5'd0, 5'd9); cyc();
    set_id(1'b1, C_RW, 5'd0, 5'd0, 5'd9); cyc();
    set_id(1'b1, C_RT, 5'd0, 5'd9, 5'd3); cyc();
    idle();
    settle(); chk("fwd.mem_prio", fb_w[0], 2'b10);
    adv();
    set_id(1'b1, C_RW, 5'd0, 5'd0, 5'd0); cyc();
    set_id(1'b1, C_RW, 5'd0, 5'd0, 5'd0); cyc();
    set_id(1'b1, C_RT, 5'd0, 5'd0, 5'd3); cyc();
    idle();
    settle(); chk("fwd.reg0", fb_w[0], 2'b00);
    adv();

    // Flush beats stall.
    set_id(1'b1, C_RW | C_MR, 5'd0, 5'd0, 5'd8); cyc();
    set_id(1'b1, C_RW | C_RS, 5'd8, 5'd0, 5'd4);
    ex_taken = 1'b1;
    settle(); chk("fl.flush", flush_w[0], 1); chk("fl.stall", stall_w[0], 0);
    adv();
    ex_taken = 1'b0; idle();
    settle(); chk("fl.bubble", exv_w[0], 0);
    adv();
    repeat (3) cyc();

    // Syscall drain and halt, then resume with go.
    set_id(1'b1, C_SYS, 5'd0, 5'd0, 5'd0);
    cyc();
    idle();
    settle(); chk("sys.stall", stall_w[0], 1); chk("sys.nohalt_stall", stall_w[1], 0);
    adv();
    cyc();
    settle(); chk("sys.not_yet", halted_w[0], 0);
    adv();
    settle(); chk("sys.halted", halted_w[0], 1);
    adv();
    go = 1'b1; cyc(); go = 1'b0;
    settle(); chk("sys.resume_h", halted_w[0], 0); chk("sys.resume_s", stall_w[0], 0);
    adv();
    go = 1'b1; cyc(); go = 1'b0;
    settle(); chk("sys.go_in_run", halted_w[0], 0);
    adv();

    // Syscall squashed by a taken branch.
    set_id(1'b1, C_SYS, 5'd0, 5'd0, 5'd0);
    ex_taken = 1'b1;
    cyc();
    ex_taken = 1'b0; idle();
    repeat (4) cyc();
    settle(); chk("sq.halted", halted_w[0], 0); chk("sq.stall", stall_w[0], 0);
    adv();

    // Asynchronous reset while draining.
    set_id(1'b1, C_SYS, 5'd0, 5'd0, 5'd0);
    cyc();
    idle();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst.stall", stall_w[0], 0);
    chk("rst.mem_valid", memv_w[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_id(1'b1, C_SYS, 5'd0, 5'd0, 5'd0);
    settle(); chk("nh.no_stall", stall_w[1], 0);
    adv();
    idle();
    cyc(); cyc();
    settle(); chk("nh.sys_wb_v", wbv_w[1], 1); chk("nh.sys_wb_c", wbc_w[1][7], 1);
    adv();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      id_ctrl  = CW'($urandom);
      id_ctrl[7] = ($urandom_range(0, 15) == 0);
      id_rs    = AW'($urandom_range(0, 3));
      id_rt    = AW'($urandom_range(0, 3));
      id_wr    = AW'($urandom_range(0, 3));
      ex_taken = ($urandom_range(0, 9) == 0);
      go       = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
